// File: rtl/synch_fifo_pkg.sv
// synch_fifo_param shared definitions.
// Sizing helpers and read-mode selectors.
package synch_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter must hold 0..DEPTH inclusive
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/synch_fifo_mem.sv
// synch_fifo_param storage array.
// One sync write port, one async read port.
module synch_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the accepted word; contents survive reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/synch_fifo_param.sv
// synch_fifo_param: parametrised single-clock FIFO.
// Std/FWFT read, thresholds, sticky errors, flush.
module synch_fifo_param
  import synch_fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en0,
  input  logic [WIDTH-1:0] write_data,
  input  logic             rd_en0,
  output logic [WIDTH-1:0] read_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             full_nxt,
  output logic             empty_nxt,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] room_avail,
  output logic [CNT_W-1:0] data_avail,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULLC = CNT_W'(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_room;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_unf;
  logic             w_clr;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_mem_we;
  logic             w_af_nxt;
  logic             w_ae_nxt;
  logic [WIDTH-1:0] w_mem_rd;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_clr    = reset | flush;
  assign w_wr_acc = wr_en0 & ~r_full;
  assign w_rd_acc = rd_en0 & ~r_empty;
  // A clearing cycle drops any in-flight write
  assign w_mem_we = w_wr_acc & ~w_clr;

  synch_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (write_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  // Next-state occupancy and pointers
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_clr) begin
      w_cnt_nxt    = '0;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_nxt = inc(r_wr_ptr);
      if (w_rd_acc) w_rd_ptr_nxt = inc(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  assign full_nxt  = (w_cnt_nxt == FULLC);
  assign empty_nxt = (w_cnt_nxt == '0);
  assign w_af_nxt  = int'(w_cnt_nxt) >= AF_LEVEL;
  assign w_ae_nxt  = int'(w_cnt_nxt) <= AE_LEVEL;

  // Pointers, counters and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_room   <= FULLC;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_room   <= FULLC - w_cnt_nxt;
      r_full   <= full_nxt;
      r_empty  <= empty_nxt;
      r_afull  <= w_af_nxt;
      r_aempty <= w_ae_nxt;
      if (flush) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (wr_en0 & r_full)  r_ovf <= 1'b1;
        if (rd_en0 & r_empty) r_unf <= 1'b1;
      end
    end
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign data_avail   = r_cnt;
  assign room_avail   = r_room;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign read_data = r_empty ? '0 : w_mem_rd;
    assign rd_valid  = ~r_empty;
  end else begin : g_std
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    // Registered pop word; valid pulses one cycle
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (flush) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_mem_rd;
      end
    end

    assign read_data = r_rd_data;
    assign rd_valid  = r_rd_valid;
  end

endmodule

// File: tb/tb_synch_fifo_param.sv
// Bench for synch_fifo_param: std D8 and FWFT D5.
// Table, directed sequences, random vs queue model.
module tb_synch_fifo_param;

  logic clk = 1'b0;
  logic reset, flush, wr_en0, rd_en0;
  logic [15:0] write_data;

  always #5 clk = ~clk;

  logic [15:0] ord[2];
  logic orv[2], ofull[2], oempty[2], ofn[2], oen[2];
  logic oaf[2], oae[2], oov[2], oun[2];
  logic [3:0] s_da, s_ra;
  logic [2:0] f_da, f_ra;
  int oda[2], ora[2];

  assign oda[0] = int'(s_da);
  assign ora[0] = int'(s_ra);
  assign oda[1] = int'(f_da);
  assign ora[1] = int'(f_ra);

  synch_fifo_param #(
    .WIDTH(16), .DEPTH(8), .FWFT(0),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en0(wr_en0), .write_data(write_data),
    .rd_en0(rd_en0), .read_data(ord[0]),
    .rd_valid(orv[0]), .full(ofull[0]),
    .empty(oempty[0]), .full_nxt(ofn[0]),
    .empty_nxt(oen[0]), .almost_full(oaf[0]),
    .almost_empty(oae[0]), .room_avail(s_ra),
    .data_avail(s_da), .overflow(oov[0]),
    .underflow(oun[0])
  );

  synch_fifo_param #(
    .WIDTH(16), .DEPTH(5), .FWFT(1),
    .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut_f (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en0(wr_en0), .write_data(write_data),
    .rd_en0(rd_en0), .read_data(ord[1]),
    .rd_valid(orv[1]), .full(ofull[1]),
    .empty(oempty[1]), .full_nxt(ofn[1]),
    .empty_nxt(oen[1]), .almost_full(oaf[1]),
    .almost_empty(oae[1]), .room_avail(f_ra),
    .data_avail(f_da), .overflow(oov[1]),
    .underflow(oun[1])
  );

  localparam int MD[2]  = '{8, 5};
  localparam int MAF[2] = '{6, 4};
  localparam int MAE[2] = '{2, 1};
  localparam int MFW[2] = '{0, 1};

  logic [15:0] mq[2][$];
  logic mov[2], mun[2], mrv[2];
  logic [15:0] mrd[2];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = mq[k].size();
      chk("data_avail", k, oda[k], sz);
      chk("room_avail", k, ora[k], MD[k] - sz);
      chk("full", k, ofull[k], sz == MD[k]);
      chk("empty", k, oempty[k], sz == 0);
      chk("almost_full", k, oaf[k], sz >= MAF[k]);
      chk("almost_empty", k, oae[k], sz <= MAE[k]);
      chk("overflow", k, oov[k], mov[k]);
      chk("underflow", k, oun[k], mun[k]);
      if (MFW[k] == 0) begin
        chk("rd_valid", k, orv[k], mrv[k]);
        chk("read_data", k, ord[k], mrd[k]);
      end else begin
        chk("rd_valid", k, orv[k], sz > 0);
        if (sz > 0) chk("read_data", k, ord[k], mq[k][0]);
      end
    end
  endtask

  task automatic step(input logic r, input logic f,
                      input logic w, input logic [15:0] d,
                      input logic rd);
    reset = r;
    flush = f;
    wr_en0 = w;
    write_data = d;
    rd_en0 = rd;
    #2;
    for (int k = 0; k < 2; k++) begin
      int sz, ns;
      sz = mq[k].size();
      if (r || f) ns = 0;
      else ns = sz + int'(w && sz < MD[k]) - int'(rd && sz > 0);
      chk("full_nxt", k, ofn[k], ns == MD[k]);
      chk("empty_nxt", k, oen[k], ns == 0);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r || f) begin
        mq[k].delete();
        mov[k] = 1'b0;
        mun[k] = 1'b0;
        mrv[k] = 1'b0;
        if (r) mrd[k] = 16'h0;
      end else begin
        int sz;
        logic wa, ra;
        sz = mq[k].size();
        wa = w && sz < MD[k];
        ra = rd && sz > 0;
        if (w && !wa) mov[k] = 1'b1;
        if (rd && !ra) mun[k] = 1'b1;
        mrv[k] = ra;
        if (ra) mrd[k] = mq[k].pop_front();
        if (wa) mq[k].push_back(d);
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0);
  endtask

  task automatic wr(input logic [15:0] d);
    step(0, 0, 1, d, 0);
  endtask

  task automatic rdp();
    step(0, 0, 0, 16'h0, 1);
  endtask

  task automatic rst();
    step(1, 0, 0, 16'h0, 0);
  endtask

  typedef struct {
    logic r, f, w;
    logic [15:0] d;
    logic rd;
    int avail;
    logic rv;
    logic [15:0] rdat;
    logic un;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    write_data = 16'h0;
    for (int k = 0; k < 2; k++) begin
      mov[k] = 1'b0;
      mun[k] = 1'b0;
      mrv[k] = 1'b0;
      mrd[k] = 16'h0;
    end
    @(negedge clk);

    tbl[0] = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0};
    tbl[1] = '{0, 0, 1, 16'hA5A5, 0, 1, 0, 16'h0000, 0};
    tbl[2] = '{0, 0, 0, 16'h0000, 1, 0, 1, 16'hA5A5, 0};
    tbl[3] = '{0, 0, 0, 16'h0000, 0, 0, 0, 16'hA5A5, 0};
    tbl[4] = '{0, 0, 1, 16'hA5A6, 0, 1, 0, 16'hA5A5, 0};
    tbl[5] = '{0, 0, 1, 16'hA5A7, 1, 1, 1, 16'hA5A6, 0};
    tbl[6] = '{0, 0, 0, 16'h0000, 1, 0, 1, 16'hA5A7, 0};
    tbl[7] = '{0, 0, 0, 16'h0000, 1, 0, 0, 16'hA5A7, 1};
    tbl[8] = '{0, 1, 0, 16'h0000, 0, 0, 0, 16'hA5A7, 0};
    tbl[9] = '{0, 1, 1, 16'h0001, 0, 0, 0, 16'hA5A7, 0};
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].rd);
      chk("tbl_avail", 0, oda[0], tbl[i].avail);
      chk("tbl_rv", 0, orv[0], tbl[i].rv);
      chk("tbl_rdat", 0, ord[0], tbl[i].rdat);
      chk("tbl_un", 0, oun[0], tbl[i].un);
    end

    // write/read pairs
    rst();
    for (int i = 0; i < 8; i++) begin
      wr(16'hA5A5 + 16'(i));
      rdp();
      chk("t1_rd", 0, ord[0], 16'hA5A5 + 16'(i));
      chk("t1_rv", 0, orv[0], 1'b1);
      idle();
      chk("t1_rv_off", 0, orv[0], 1'b0);
    end
    chk("t1_avail", 0, oda[0], 0);
    chk("t1_empty", 0, oempty[0], 1'b1);

    // fill, overflow, drain, underflow
    rst();
    for (int i = 1; i <= 7; i++) wr(16'hFFFF - 16'(i));
    wr_en0 = 1'b1;
    write_data = 16'hFFF7;
    #2;
    chk("t2_full_nxt", 0, ofn[0], 1'b1);
    wr(16'hFFF7);
    chk("t2_full", 0, ofull[0], 1'b1);
    chk("t2_room", 0, ora[0], 0);
    wr(16'h0BAD);
    chk("t2_ovf", 0, oov[0], 1'b1);
    chk("t2_avail", 0, oda[0], 8);
    for (int i = 1; i <= 10; i++) begin
      rdp();
      if (i <= 8) chk("t2_rd", 0, ord[0], 16'hFFFF - 16'(i));
    end
    chk("t2_hold", 0, ord[0], 16'hFFF7);
    chk("t2_unf", 0, oun[0], 1'b1);

    // steady occupancy with wrap
    rst();
    for (int i = 0; i < 4; i++) wr(16'd100 + 16'(i));
    for (int j = 0; j < 20; j++) begin
      step(0, 0, 1, 16'd200 + 16'(j), 1);
      chk("t3_avail", 0, oda[0], 4);
    end
    for (int i = 0; i < 4; i++) rdp();
    chk("t3_last", 0, ord[0], 16'd219);

    // FWFT visibility
    rst();
    wr_en0 = 1'b1;
    write_data = 16'h1234;
    #2;
    chk("t4_nobypass", 1, orv[1], 1'b0);
    wr(16'h1234);
    chk("t4_empty", 1, oempty[1], 1'b0);
    chk("t4_rv", 1, orv[1], 1'b1);
    chk("t4_rd", 1, ord[1], 16'h1234);
    rdp();
    chk("t4_empty2", 1, oempty[1], 1'b1);
    chk("t4_rv2", 1, orv[1], 1'b0);

    // thresholds
    rst();
    for (int i = 1; i <= 6; i++) begin
      wr(16'(i));
      chk("t5_af", 0, oaf[0], i >= 6);
      chk("t5_ae", 0, oae[0], i <= 2);
    end
    rdp();
    chk("t5_af5", 0, oaf[0], 1'b0);

    // flush and held reset
    rst();
    for (int i = 0; i < 9; i++) wr(16'h0300 + 16'(i));
    for (int i = 0; i < 3; i++) rdp();
    chk("t6_ovf", 0, oov[0], 1'b1);
    chk("t6_avail5", 0, oda[0], 5);
    step(0, 1, 1, 16'hDEAD, 0);
    chk("t6_f_avail", 0, oda[0], 0);
    chk("t6_f_empty", 0, oempty[0], 1'b1);
    chk("t6_f_ovf", 0, oov[0], 1'b0);
    chk("t6_f_rd", 0, ord[0], 16'h0302);
    for (int i = 0; i < 9; i++) wr(16'h0400 + 16'(i));
    rdp();
    step(1, 0, 1, 16'hBEEF, 1);
    step(1, 0, 1, 16'hBEEF, 1);
    chk("t6_r_avail", 0, oda[0], 0);
    chk("t6_r_room", 0, ora[0], 8);
    chk("t6_r_ovf", 0, oov[0], 1'b0);
    chk("t6_r_rd", 0, ord[0], 16'h0);
    chk("t6_r_rv", 0, orv[0], 1'b0);
    chk("t6_r_ae", 0, oae[0], 1'b1);

    // random traffic
    rst();
    for (int ph = 0; ph < 3; ph++) begin
      int wp;
      wp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
      for (int n = 0; n < 1000; n++) begin
        logic r, f, w, rd;
        r = ($urandom_range(0, 199) == 0);
        f = ($urandom_range(0, 99) == 0);
        w = ($urandom_range(0, 99) < wp);
        rd = ($urandom_range(0, 99) < 100 - wp);
        step(r, f, w, 16'($urandom), rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
